// File: rtl/pacman_pkg.sv
// Shared types and defaults for the dot pipeline: the dots stage, the
// scoreboard and the HUD all agree on the dot count and the value of one dot.
package pacman_pkg;

  localparam int N_DOTS_DEFAULT     = 32;
  localparam int DOT_POINTS_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    RST_DOTS,
    SETTLE,
    PLAY,
    CLEAR
  } sb_state_t;

endpackage

// File: rtl/dot_popcount.sv
// Combinational population count of an N_DOTS-wide vector.
//   bits  : vector to count
//   count : number of set bits, 0..N_DOTS
module dot_popcount #(
  parameter int N_DOTS = 32,
  parameter int CNT_W  = $clog2(N_DOTS + 1)
) (
  input  logic [N_DOTS-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_DOTS; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/dot_scoreboard.sv
// Scores newly eaten dots, tracks dots left in the level, and sequences
// level clear / restart, pulsing dots_reset to clear the dots stage.
//   Clk, Reset     : clock, asynchronous active-high reset
//   frame_tick     : one-cycle pulse per video frame (paces the CLEAR pause)
//   game_start     : starts or restarts a game (score and level to 0)
//   eaten          : per-dot eaten flags from the dots stage
//   dots_reset     : one-cycle pulse clearing the dots stage
//   score          : saturating score, kept across levels
//   dots_remaining : uneaten dots in the current level
//   level          : 0-based level, wraps
//   level_clear    : high while in CLEAR
//   playing        : high while in PLAY
module dot_scoreboard
  import pacman_pkg::*;
#(
  parameter int N_DOTS       = N_DOTS_DEFAULT,
  parameter int DOT_POINTS   = DOT_POINTS_DEFAULT,
  parameter int SCORE_W      = 16,
  parameter int LEVEL_W      = 4,
  parameter int CLEAR_FRAMES = 120,
  localparam int REM_W       = $clog2(N_DOTS + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               game_start,
  input  logic [N_DOTS-1:0]  eaten,
  output logic               dots_reset,
  output logic [SCORE_W-1:0] score,
  output logic [REM_W-1:0]   dots_remaining,
  output logic [LEVEL_W-1:0] level,
  output logic               level_clear,
  output logic               playing
);

  localparam int CNT_W = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;
  localparam int SUM_W = SCORE_W + 8;
  localparam logic [SUM_W-1:0]   PTS       = SUM_W'(DOT_POINTS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLEAR_FRAMES - 1);

  sb_state_t          state_q, state_d;
  logic [N_DOTS-1:0]  eaten_q, eaten_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   clear_cnt_q, clear_cnt_d;
  logic               dots_reset_q, dots_reset_d;
  logic               level_clear_q, level_clear_d;
  logic               playing_q, playing_d;

  logic [N_DOTS-1:0]  new_bits;
  logic [REM_W-1:0]   k;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_sat;
  logic [REM_W-1:0]   rem_sub;

  assign new_bits = eaten & ~eaten_q;

  dot_popcount #(.N_DOTS(N_DOTS), .CNT_W(REM_W)) u_popcount (
    .bits  (new_bits),
    .count (k)
  );

  // Widened sum so the saturation compare sees the true total.
  assign sum       = SUM_W'(score_q) + SUM_W'(k) * PTS;
  assign score_sat = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
  assign rem_sub   = (k >= rem_q) ? '0 : rem_q - k;

  always_comb begin
    state_d     = state_q;
    eaten_d     = eaten_q;
    score_d     = score_q;
    rem_d       = rem_q;
    level_d     = level_q;
    clear_cnt_d = clear_cnt_q;
    case (state_q)
      IDLE: begin
        if (game_start) begin
          state_d = RST_DOTS;
          score_d = '0;
          level_d = '0;
        end
      end
      RST_DOTS: begin
        rem_d   = REM_W'(N_DOTS);
        eaten_d = '0;
        state_d = SETTLE;
      end
      // Dots stage is still clearing; take its vector as the baseline only.
      SETTLE: begin
        eaten_d = eaten;
        state_d = PLAY;
      end
      PLAY: begin
        eaten_d = eaten;
        if (game_start) begin
          state_d = RST_DOTS;
          score_d = '0;
          level_d = '0;
        end else begin
          score_d = score_sat;
          rem_d   = rem_sub;
          if (rem_q == '0) begin
            state_d     = CLEAR;
            clear_cnt_d = '0;
          end
        end
      end
      CLEAR: begin
        eaten_d = eaten;
        if (game_start) begin
          state_d = RST_DOTS;
          score_d = '0;
          level_d = '0;
        end else if (frame_tick) begin
          if (clear_cnt_q == CNT_LAST) begin
            level_d = level_q + 1'b1;
            state_d = RST_DOTS;
          end else begin
            clear_cnt_d = clear_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Status outputs decode the next state so they register in step with it.
    dots_reset_d  = (state_d == RST_DOTS);
    level_clear_d = (state_d == CLEAR);
    playing_d     = (state_d == PLAY);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      eaten_q       <= '0;
      score_q       <= '0;
      rem_q         <= REM_W'(N_DOTS);
      level_q       <= '0;
      clear_cnt_q   <= '0;
      dots_reset_q  <= 1'b0;
      level_clear_q <= 1'b0;
      playing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      eaten_q       <= eaten_d;
      score_q       <= score_d;
      rem_q         <= rem_d;
      level_q       <= level_d;
      clear_cnt_q   <= clear_cnt_d;
      dots_reset_q  <= dots_reset_d;
      level_clear_q <= level_clear_d;
      playing_q     <= playing_d;
    end
  end

  assign dots_reset     = dots_reset_q;
  assign score          = score_q;
  assign dots_remaining = rem_q;
  assign level          = level_q;
  assign level_clear    = level_clear_q;
  assign playing        = playing_q;

endmodule

// File: tb/tb_dot_scoreboard.sv
module tb_dot_scoreboard;

  localparam int N = 32;
  localparam int PH_IDLE = 0, PH_RST = 1, PH_SETTLE = 2, PH_PLAY = 3, PH_CLEAR = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          game_start = 1'b0;
  logic [N-1:0]  eaten = '0;

  logic          dots_reset, level_clear, playing;
  logic [15:0]   score;
  logic [5:0]    dots_remaining;
  logic [3:0]    level;

  logic          dots_reset8, level_clear8, playing8;
  logic [7:0]    score8;
  logic [5:0]    dots_remaining8;
  logic [3:0]    level8;

  int checks = 0;
  int errors = 0;

  // Reference model: frames-in-clear counted up to 120, score as an unbounded total.
  int           m_phase, m_total, m_rem, m_level, m_frames;
  logic [N-1:0] m_prev;

  dot_scoreboard #(.N_DOTS(32), .DOT_POINTS(10), .SCORE_W(16), .LEVEL_W(4), .CLEAR_FRAMES(120)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_start(game_start), .eaten(eaten),
    .dots_reset(dots_reset), .score(score), .dots_remaining(dots_remaining), .level(level),
    .level_clear(level_clear), .playing(playing));

  dot_scoreboard #(.N_DOTS(32), .DOT_POINTS(10), .SCORE_W(8), .LEVEL_W(4), .CLEAR_FRAMES(120)) dut8 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_start(game_start), .eaten(eaten),
    .dots_reset(dots_reset8), .score(score8), .dots_remaining(dots_remaining8), .level(level8),
    .level_clear(level_clear8), .playing(playing8));

  always #5 Clk = ~Clk;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_total = 0; m_rem = N; m_level = 0; m_frames = 0; m_prev = '0;
  endtask

  task automatic model_step();
    int k;
    case (m_phase)
      PH_IDLE: if (game_start) begin m_phase = PH_RST; m_total = 0; m_level = 0; end
      PH_RST: begin m_rem = N; m_prev = '0; m_phase = PH_SETTLE; end
      PH_SETTLE: begin m_prev = eaten; m_phase = PH_PLAY; end
      PH_PLAY: begin
        if (game_start) begin
          m_phase = PH_RST; m_total = 0; m_level = 0;
        end else begin
          k = $countones(eaten & ~m_prev);
          if (m_rem == 0) begin m_phase = PH_CLEAR; m_frames = 0; end
          m_total = m_total + 10 * k;
          m_rem = (m_rem > k) ? m_rem - k : 0;
        end
        m_prev = eaten;
      end
      default: begin
        if (game_start) begin
          m_phase = PH_RST; m_total = 0; m_level = 0;
        end else if (frame_tick) begin
          m_frames++;
          if (m_frames == 120) begin m_level = (m_level + 1) % 16; m_phase = PH_RST; end
        end
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (dots_remaining !== 6'd32) begin errors++; $display("FAIL reset_rem got=%0d exp=32", dots_remaining); end
    checks++; if ({dots_reset, level_clear, playing, level} !== 7'd0) begin errors++;
      $display("FAIL reset_flags got=%b exp=0000000", {dots_reset, level_clear, playing, level}); end
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_start();
    game_start = 1'b1; tick(); game_start = 1'b0;
    checks++; if (dots_reset !== 1'b1) begin errors++; $display("FAIL start_pulse got=%b exp=1", dots_reset); end
    tick();
    checks++; if ({dots_reset, playing} !== 2'b00) begin errors++; $display("FAIL start_settle got=%b exp=00", {dots_reset, playing}); end
    tick();
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL start_playing got=%b exp=1", playing); end
    checks++; if (score !== 16'd0 || dots_remaining !== 6'd32) begin errors++;
      $display("FAIL start_vals got=%0d/%0d exp=0/32", score, dots_remaining); end
  endtask

  task automatic test_single();
    eaten[3] = 1'b1;
    tick();
    checks++; if (score !== 16'd10 || dots_remaining !== 6'd31) begin errors++;
      $display("FAIL single got=%0d/%0d exp=10/31", score, dots_remaining); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (score !== 16'd10 || dots_remaining !== 6'd31) begin errors++;
        $display("FAIL single_held cyc=%0d got=%0d/%0d exp=10/31", i, score, dots_remaining); end
    end
  endtask

  task automatic test_multi();
    eaten = '0;
    game_start = 1'b1; tick(); game_start = 1'b0;
    tick(); tick();
    eaten[0] = 1'b1; eaten[5] = 1'b1; eaten[9] = 1'b1;
    tick();
    checks++; if (score !== 16'd30 || dots_remaining !== 6'd29) begin errors++;
      $display("FAIL multi got=%0d/%0d exp=30/29", score, dots_remaining); end
  endtask

  task automatic test_clear();
    int guard = 0;
    while (eaten != '1 && guard < 200) begin
      eaten = eaten | ($urandom() & $urandom() & $urandom());
      if (guard == 199) eaten = '1;
      tick();
      guard++;
      checks++; if (score !== 16'(sat(m_total, 65535)) || dots_remaining !== 6'(m_rem)) begin errors++;
        $display("FAIL clear_eat got=%0d/%0d exp=%0d/%0d", score, dots_remaining, sat(m_total, 65535), m_rem); end
    end
    checks++; if (dots_remaining !== 6'd0 || level_clear !== 1'b0) begin errors++;
      $display("FAIL clear_zero got=%0d/%b exp=0/0", dots_remaining, level_clear); end
    tick();
    checks++; if (level_clear !== 1'b1 || playing !== 1'b0) begin errors++;
      $display("FAIL clear_enter got=%b/%b exp=1/0", level_clear, playing); end
    checks++; if (score !== 16'd320) begin errors++; $display("FAIL clear_score got=%0d exp=320", score); end
    checks++; if (score8 !== 8'd255) begin errors++; $display("FAIL sat_score8 got=%0d exp=255", score8); end
    for (int i = 0; i < 120; i++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      if (i < 119) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        checks++; if (level_clear !== 1'b1) begin errors++; $display("FAIL clear_hold frame=%0d got=%b exp=1", i, level_clear); end
      end
    end
    checks++; if (dots_reset !== 1'b1 || level !== 4'd1 || level_clear !== 1'b0) begin errors++;
      $display("FAIL clear_next got=%b/%0d/%b exp=1/1/0", dots_reset, level, level_clear); end
    eaten = '0;
    tick();
    checks++; if (dots_reset !== 1'b0 || dots_remaining !== 6'd32) begin errors++;
      $display("FAIL clear_rearm got=%b/%0d exp=0/32", dots_reset, dots_remaining); end
    tick();
    checks++; if (playing !== 1'b1 || score !== 16'd320 || score8 !== 8'd255) begin errors++;
      $display("FAIL clear_kept got=%b/%0d/%0d exp=1/320/255", playing, score, score8); end
  endtask

  task automatic test_clear_restart();
    eaten = '1;
    tick();
    checks++; if (score !== 16'd640 || dots_remaining !== 6'd0) begin errors++;
      $display("FAIL all_at_once got=%0d/%0d exp=640/0", score, dots_remaining); end
    tick();
    for (int i = 0; i < 5; i++) begin frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick(); end
    checks++; if (level_clear !== 1'b1) begin errors++; $display("FAIL restart_inclear got=%b exp=1", level_clear); end
    game_start = 1'b1; tick(); game_start = 1'b0;
    checks++; if (dots_reset !== 1'b1 || level !== 4'd0 || score !== 16'd0 || level_clear !== 1'b0) begin errors++;
      $display("FAIL restart got=%b/%0d/%0d/%b exp=1/0/0/0", dots_reset, level, score, level_clear); end
    tick();
    tick();
    checks++; if (playing !== 1'b1 || score !== 16'd0 || dots_remaining !== 6'd32) begin errors++;
      $display("FAIL stale_settle got=%b/%0d/%0d exp=1/0/32", playing, score, dots_remaining); end
    eaten = '0;
    tick();
    checks++; if (score !== 16'd0 || score8 !== 8'd0 || dots_remaining !== 6'd32) begin errors++;
      $display("FAIL falling_edges got=%0d/%0d/%0d exp=0/0/32", score, score8, dots_remaining); end
  endtask

  task automatic test_mid_reset();
    eaten[7] = 1'b1;
    tick();
    checks++; if (score !== 16'd10) begin errors++; $display("FAIL pre_reset got=%0d exp=10", score); end
    #3 Reset = 1'b1;
    #1;
    checks++; if (score !== 16'd0 || dots_remaining !== 6'd32 || {playing, level_clear, dots_reset, level} !== 7'd0) begin
      errors++; $display("FAIL async_reset got=%0d/%0d/%b exp=0/32/0", score, dots_remaining,
        {playing, level_clear, dots_reset, level}); end
    model_reset();
    eaten = '0;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_random();
    int r;
    game_start = 1'b1; tick(); game_start = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (dots_reset === 1'b1) eaten = '0;
      else begin
        r = $urandom_range(0, 99);
        if (r < 40) eaten[$urandom_range(0, N - 1)] = 1'b1;
        else if (r < 45) eaten[$urandom_range(0, N - 1)] = 1'b0;
      end
      frame_tick = ($urandom_range(0, 3) == 0);
      game_start = ($urandom_range(0, 599) == 0);
      tick();
      game_start = 1'b0; frame_tick = 1'b0;
      checks++;
      if (score !== 16'(sat(m_total, 65535)) || score8 !== 8'(sat(m_total, 255)) ||
          dots_remaining !== 6'(m_rem) || level !== 4'(m_level) ||
          dots_reset !== (m_phase == PH_RST) || playing !== (m_phase == PH_PLAY) ||
          level_clear !== (m_phase == PH_CLEAR)) begin
        errors++;
        $display("FAIL random cyc=%0d got=%0d/%0d/%0d/%0d/%b%b%b exp=%0d/%0d/%0d/%0d/%b%b%b", c,
          score, score8, dots_remaining, level, dots_reset, playing, level_clear,
          sat(m_total, 65535), sat(m_total, 255), m_rem, m_level,
          m_phase == PH_RST, m_phase == PH_PLAY, m_phase == PH_CLEAR);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_single();
    test_multi();
    test_clear();
    test_clear_restart();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
